// File: rtl/bp_fe_fetch_queue.sv
// bp_fe_fetch_queue
//   Circular-buffer queue that sits between the icache fetch stage and the
//   decode front end. Non-speculative fetches are enqueued. A speculative
//   miss stores nothing and instead raises a one-cycle replay request for
//   its PC on the following cycle. A fetch that arrives while the queue is
//   full is dropped silently, and upstream retries it.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   reset_n_i      synchronous active-low reset
//   fetch_v_i      fetch result valid
//   fetch_data_i   fetched instruction bits
//   fetch_pc_i     PC of the fetch
//   fetch_spec_i   speculative miss, carries no data
//   fetch_ready_o  queue can accept a fetch this cycle
//   flush_i        discard every entry and any replay capture
//   deq_v_o        head entry valid
//   deq_data_o     head data
//   deq_pc_o       head PC
//   deq_yumi_i     consumer takes the head
//   replay_v_o     one-cycle refetch request
//   replay_pc_o    PC to refetch
//   count_o        current occupancy

module bp_fe_fetch_queue #(
    parameter int depth_p       = 4,
    parameter int fetch_width_p = 32,
    parameter int vaddr_width_p = 39
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           fetch_v_i,
    input  logic [fetch_width_p-1:0]       fetch_data_i,
    input  logic [vaddr_width_p-1:0]       fetch_pc_i,
    input  logic                           fetch_spec_i,
    output logic                           fetch_ready_o,

    input  logic                           flush_i,

    output logic                           deq_v_o,
    output logic [fetch_width_p-1:0]       deq_data_o,
    output logic [vaddr_width_p-1:0]       deq_pc_o,
    input  logic                           deq_yumi_i,

    output logic                           replay_v_o,
    output logic [vaddr_width_p-1:0]       replay_pc_o,

    output logic [$clog2(depth_p):0]       count_o
);

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(depth_p);

    logic [fetch_width_p-1:0] data_mem_q [depth_p];
    logic [vaddr_width_p-1:0] pc_mem_q   [depth_p];

    logic [ptr_w_lp-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0]      wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]      count_q,  count_d;
    logic                     replay_v_q, replay_v_d;
    logic [vaddr_width_p-1:0] replay_pc_q, replay_pc_d;

    logic enq, deq;

    // Ready depends only on the registered count, so a dequeue in the same
    // cycle never frees a slot for a fetch arriving that cycle.
    assign fetch_ready_o = (count_q != full_cnt_lp);
    assign deq_v_o       = (count_q != '0);

    assign enq = fetch_v_i & fetch_ready_o & ~fetch_spec_i & ~flush_i;
    assign deq = deq_yumi_i & deq_v_o & ~flush_i;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        replay_v_d  = 1'b0;
        replay_pc_d = replay_pc_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
            if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
            if (enq && !deq)      count_d = count_q + cnt_w_lp'(1);
            else if (deq && !enq) count_d = count_q - cnt_w_lp'(1);

            // Speculative misses replay regardless of fill level.
            if (fetch_v_i && fetch_spec_i) begin
                replay_v_d  = 1'b1;
                replay_pc_d = fetch_pc_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            replay_v_q  <= 1'b0;
            replay_pc_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            replay_v_q  <= replay_v_d;
            replay_pc_q <= replay_pc_d;
        end
    end

    // Storage is left unreset; the occupancy count alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            data_mem_q[wr_ptr_q] <= fetch_data_i;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_i;
        end
    end

    assign deq_data_o  = data_mem_q[rd_ptr_q];
    assign deq_pc_o    = pc_mem_q[rd_ptr_q];
    assign replay_v_o  = replay_v_q;
    assign replay_pc_o = replay_pc_q;
    assign count_o     = count_q;

endmodule
